inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
// - Program-counter and instruction-fetch stage sitting directly upstream of the instruction decoder.
// - Holds the PC and fetches one 32-bit instruction per step from instruction memory over a req/ack handshake.
// - Presents the instruction to the decoder, then selects the next PC from the decoder's 2-bit PC_s:
//   sequential, jr, branch or jump. Also supplies pc_plus4 as the jal link value.
// PARAMETERS
// - RESET_PC     32'h0000_0000  PC loaded on reset; must be word aligned
// - TIMEOUT_CYC  255            max WAIT cycles before fetch_fault; range 1..255 (8-bit counter)
// PORTS
// - clk          in   1   rising-edge clock
// - rst_n        in   1   asynchronous active-low reset
// - imem_req     out  1   fetch request; held high until imem_ack
// - imem_addr    out  32  fetch address (= pc); stable while imem_req
// - imem_ack     in   1   memory returns imem_rdata this cycle
// - imem_rdata   in   32  instruction word, valid with imem_ack
// - inst         out  32  registered instruction to decoder
// - inst_valid   out  1   inst is current; decoder outputs are sampled this cycle
// - stall        in   1   hold in EXEC; PC does not advance
// - PC_s         in   2   next-PC select from decoder: 00 +4, 01 jr, 10 branch, 11 jump
// - imm          in   16  branch offset from decoder
// - address      in   26  jump target field from decoder
// - rs_data      in   32  register rs value, used for jr
// - pc           out  32  current PC
// - pc_plus4     out  32  pc + 4; jal link value
// - fetch_fault  out  1   sticky; memory timeout or misaligned target
// BEHAVIOUR
// - Reset values (async, rst_n low): pc = RESET_PC, inst = 32'h0, inst_valid = 0, imem_req = 0,
//   fetch_fault = 0, timeout counter = 0. State goes to BOOT.
// - FSM states:
//   - BOOT: one cycle after reset release, then REQ.
//   - REQ: imem_req = 1, counter cleared, go to WAIT next cycle.
//   - WAIT: imem_req held at 1. On imem_ack: inst <= imem_rdata, go to EXEC.
//     Otherwise the counter increments; when it reaches TIMEOUT_CYC, set fetch_fault and go to HALT.
//   - EXEC: inst_valid = 1 and imem_req = 0.
//     - stall = 1: stay in EXEC; pc and inst are held.
//     - stall = 0: pc <= next_pc, go to REQ.
//   - HALT: all outputs frozen. Left only by reset.
// - An imem_ack in the same cycle imem_req rises (REQ) is ignored; only acks in WAIT are accepted.
// - Minimum fetch latency: 3 cycles per instruction (REQ, WAIT with ack, EXEC).
// - Next-PC rules (combinational, evaluated in EXEC):
//   - 00: pc_plus4
//   - 01: rs_data
//   - 10: pc_plus4 + {{14{imm[15]}}, imm, 2'b00}
//   - 11: {pc_plus4[31:28], address, 2'b00}
// - Arithmetic is modulo 2^32. pc = 32'hFFFF_FFFC with PC_s = 00 wraps to 32'h0 with no fault.
// - A next_pc with bits [1:0] != 0 (only possible via jr): set fetch_fault, go to HALT, pc unchanged.
// - PC_s is sampled only in EXEC; its value in other states is don't-care.
// - Reset asserted mid-WAIT: imem_req drops asynchronously. A later ack from the aborted request
//   is ignored because the FSM is in BOOT/REQ, not WAIT.
// CONFIGURATION
// - Macro IFU_PERF_CNT_EN.
// - Defined: adds outputs perf_fetch_cnt[31:0] and perf_redirect_cnt[31:0], both reset to 0.
//   - perf_fetch_cnt increments on each EXEC->REQ transition.
//   - perf_redirect_cnt increments on each EXEC->REQ transition where PC_s != 00.
//   - Both counters wrap modulo 2^32 and freeze in HALT.
// - Undefined: the ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
// - Shared package cpu_pkg: PC_s encodings (PCS_SEQ, PCS_JR, PCS_BR, PCS_J), FSM state typedef
//   ifu_state_t, INST_W = 32.
// - One natural sub-module: next_pc_calc (purely combinational; inputs pc, PC_s, imm, address,
//   rs_data; outputs next_pc, misalign).
// TESTING
// - Reset, RESET_PC = 0, memory acks after 1 cycle -> imem_addr sequence 0, 4, 8;
//   inst_valid pulses every 3 cycles.
// - pc = 32'h40, PC_s = 10, imm = 16'hFFFF -> next pc = 32'h40 (loop). With imm = 16'h0003 -> next pc = 32'h50.
// - pc = 32'h1000_0000, PC_s = 11, address = 26'h0000100 -> next pc = 32'h1000_0400;
//   pc_plus4 = 32'h1000_0004 during EXEC.
// - PC_s = 01, rs_data = 32'h0000_0102 -> fetch_fault = 1, HALT, no further imem_req.
//   Repeat with rs_data = 32'h200 -> pc = 32'h200.
// - Memory never acks, TIMEOUT_CYC = 4 -> fetch_fault set after 4 WAIT cycles.
//   stall = 1 for 5 cycles in EXEC -> pc and inst held, one fetch only.
// - rst_n pulsed low during WAIT, then a late ack -> pc = RESET_PC, late ack ignored;
//   with IFU_PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select encodings, fetch FSM states, instruction width.
package cpu_pkg;

  localparam int INST_W = 32;

  typedef enum logic [1:0] {
    PCS_SEQ = 2'b00,
    PCS_JR  = 2'b01,
    PCS_BR  = 2'b10,
    PCS_J   = 2'b11
  } pcs_t;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_REQ,
    ST_WAIT,
    ST_EXEC,
    ST_HALT
  } ifu_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, jr, PC-relative branch, or pseudo-direct jump.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  PC_s,
  input  logic [15:0] imm,
  input  logic [25:0] address,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] pc_plus4;
  logic [31:0] br_off;

  assign pc_plus4 = pc + 32'd4;
  assign br_off   = {{14{imm[15]}}, imm, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    unique case (pcs_t'(PC_s))
      PCS_SEQ: next_pc = pc_plus4;
      PCS_JR:  next_pc = rs_data;
      PCS_BR:  next_pc = pc_plus4 + br_off;
      PCS_J:   next_pc = {pc_plus4[31:28], address, 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

  // Only jr can produce a non-word target; the other paths are aligned by construction.
  assign misalign = |next_pc[1:0];

endmodule

// File: rtl/inst_fetch_unit.sv
// PC register and req/ack instruction fetch FSM feeding the decoder.
// Optional performance counters enabled by defining IFU_PERF_CNT_EN.
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  input  logic              stall,
  input  logic [1:0]        PC_s,
  input  logic [15:0]       imm,
  input  logic [25:0]       address,
  input  logic [31:0]       rs_data,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              fetch_fault
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_redirect_cnt
`endif
);

  localparam logic [7:0] TMO = TIMEOUT_CYC[7:0];

  ifu_state_t        state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              fault_q, fault_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              advance;
  logic [31:0]       next_pc;
  logic              misalign;

  next_pc_calc u_next_pc_calc (
    .pc       (pc_q),
    .PC_s     (PC_s),
    .imm      (imm),
    .address  (address),
    .rs_data  (rs_data),
    .next_pc  (next_pc),
    .misalign (misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    advance = 1'b0;
    unique case (state_q)
      ST_BOOT: state_d = ST_REQ;
      ST_REQ: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = ST_EXEC;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TMO) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          if (misalign) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_d    = next_pc;
            advance = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
  end

  // Decoded from state so an async reset drops imem_req immediately.
  assign imem_req    = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign inst_valid  = (state_q == ST_EXEC);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign inst        = inst_q;
  assign fetch_fault = fault_q;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, redirect_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else if (advance) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (pcs_t'(PC_s) != PCS_SEQ) redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt    = fetch_cnt_q;
  assign perf_redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: next-PC table plus hand-written fetch, stall, fault and reset sequences.
module tb_inst_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        stall = 1'b0;
  logic [1:0]  PC_s = 2'b00;
  logic [15:0] imm = '0;
  logic [25:0] address = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_fault;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_redirect_cnt;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  inst_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .stall       (stall),
    .PC_s        (PC_s),
    .imm         (imm),
    .address     (address),
    .rs_data     (rs_data),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_fault (fetch_fault)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    stall    = 1'b0;
    PC_s     = PCS_SEQ;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_imem_req", {31'b0, imem_req}, 32'h0);
    check("rst_fault", {31'b0, fetch_fault}, 32'h0);
`ifdef IFU_PERF_CNT_EN
    check("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    check("rst_perf_redir", perf_redirect_cnt, 32'h0);
`endif
    rst_n = 1'b1;
  endtask

  // Waits for the REQ cycle, acks in the first WAIT cycle (+extra), returns in EXEC.
  task automatic do_fetch(input logic [31:0] word, input int unsigned extra,
                          output logic [31:0] req_addr);
    logic seen;
    seen = 1'b0;
    req_addr = 'x;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (imem_req) begin
        seen = 1'b1;
        break;
      end
    end
    check("req_seen", {31'b0, seen}, 32'h1);
    if (seen) begin
      req_addr = imem_addr;
      @(negedge clk);
      repeat (extra) @(negedge clk);
      imem_ack   = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      imem_ack = 1'b0;
      check("exec_inst", inst, word);
      check("exec_valid", {31'b0, inst_valid}, 32'h1);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] start_pc;
    logic [1:0]  pcs;
    logic [15:0] imm;
    logic [25:0] addr;
    logic [31:0] rs;
    logic [31:0] exp_next;
    logic [31:0] exp_plus4;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] a;
    int unsigned t0, t1;
    logic [31:0] p, w;
    logic        bad;

    vecs[0] = '{"br_loop",   32'h0000_0040, PCS_BR,  16'hFFFF, 26'h0,       32'h0,     32'h0000_0040, 32'h0000_0044};
    vecs[1] = '{"br_fwd",    32'h0000_0040, PCS_BR,  16'h0003, 26'h0,       32'h0,     32'h0000_0050, 32'h0000_0044};
    vecs[2] = '{"jump",      32'h1000_0000, PCS_J,   16'h0,    26'h0000100, 32'h0,     32'h1000_0400, 32'h1000_0004};
    vecs[3] = '{"jr_200",    32'h0000_0040, PCS_JR,  16'h0,    26'h0,       32'h200,   32'h0000_0200, 32'h0000_0044};
    vecs[4] = '{"seq_wrap",  32'hFFFF_FFFC, PCS_SEQ, 16'h0,    26'h0,       32'h0,     32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{"seq",       32'h0000_0100, PCS_SEQ, 16'h0,    26'h0,       32'h0,     32'h0000_0104, 32'h0000_0104};
    vecs[6] = '{"br_neg_max",32'h0000_0080, PCS_BR,  16'h8000, 26'h0,       32'h0,     32'hFFFE_0084, 32'h0000_0084};
    vecs[7] = '{"jump_hi",   32'hF000_0000, PCS_J,   16'h0,    26'h3FFFFFF, 32'h0,     32'hFFFF_FFFC, 32'hF000_0004};

    // Basic sequential fetch: addresses 0,4,8 with a 3-cycle cadence.
    apply_reset();
    do_fetch(32'hA000_0000, 0, a);
    check("seq_addr0", a, 32'h0);
    t0 = cyc;
    do_fetch(32'hA000_0001, 0, a);
    check("seq_addr1", a, 32'h4);
    t1 = cyc;
    check("cadence01", t1 - t0, 32'd3);
    t0 = t1;
    do_fetch(32'hA000_0002, 0, a);
    check("seq_addr2", a, 32'h8);
    check("cadence12", cyc - t0, 32'd3);
`ifdef IFU_PERF_CNT_EN
    check("perf_fetch_2", perf_fetch_cnt, 32'd2);
    check("perf_redir_0", perf_redirect_cnt, 32'd0);
`endif

    // Next-PC table: jr to start_pc, then apply the vector's select.
    for (int i = 0; i < 8; i++) begin
      PC_s    = PCS_JR;
      rs_data = vecs[i].start_pc;
      do_fetch(32'hB000_0000 + i, 0, a);
      check({vecs[i].name, "_start"}, a, vecs[i].start_pc);
      check({vecs[i].name, "_pc"}, pc, vecs[i].start_pc);
      check({vecs[i].name, "_plus4"}, pc_plus4, vecs[i].exp_plus4);
      PC_s    = vecs[i].pcs;
      imm     = vecs[i].imm;
      address = vecs[i].addr;
      rs_data = vecs[i].rs;
      do_fetch(32'hC000_0000 + i, 0, a);
      check({vecs[i].name, "_next"}, a, vecs[i].exp_next);
      check({vecs[i].name, "_fault"}, {31'b0, fetch_fault}, 32'h0);
    end

    // Stall holds pc/inst in EXEC with no new request.
    p = pc;
    w = inst;
    stall = 1'b1;
    PC_s  = PCS_SEQ;
    bad   = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (pc !== p || inst !== w || inst_valid !== 1'b1 || imem_req !== 1'b0) bad = 1'b1;
    end
    check("stall_hold", {31'b0, bad}, 32'h0);
    stall = 1'b0;
    do_fetch(32'hD000_0000, 1, a);
    check("after_stall_addr", a, p + 32'd4);

    // Misaligned jr: sticky fault, halt, pc unchanged, no more requests.
    p       = pc;
    PC_s    = PCS_JR;
    rs_data = 32'h0000_0102;
    @(negedge clk);
    check("misalign_fault", {31'b0, fetch_fault}, 32'h1);
    check("misalign_pc", pc, p);
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || fetch_fault !== 1'b1) bad = 1'b1;
    end
    check("halt_no_req", {31'b0, bad}, 32'h0);

    // Memory never acks: fault after 4 WAIT cycles.
    apply_reset();
    PC_s = PCS_SEQ;
    bad  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (imem_req) begin
        bad = 1'b0;
        break;
      end
    end
    check("tmo_req_seen", {31'b0, bad}, 32'h0);
    repeat (4) @(negedge clk);
    check("tmo_not_yet", {31'b0, fetch_fault}, 32'h0);
    @(negedge clk);
    check("tmo_fault", {31'b0, fetch_fault}, 32'h1);
    check("tmo_req_low", {31'b0, imem_req}, 32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hEEEE_EEEE;
    repeat (2) @(negedge clk);
    imem_ack = 1'b0;
    check("tmo_halt_inst", inst, 32'h0);

    // Reset during WAIT, followed by a late ack that must be ignored.
    apply_reset();
    do_fetch(32'h1234_5678, 0, a);
    PC_s    = PCS_JR;
    rs_data = 32'h0000_0300;
    bad     = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (imem_req) begin
        bad = 1'b0;
        break;
      end
    end
    check("rw_req_addr", imem_addr, 32'h300);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rw_req_drop", {31'b0, imem_req}, 32'h0);
    check("rw_pc_reset", pc, 32'h0);
    @(negedge clk);
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rw_late_valid", {31'b0, inst_valid}, 32'h0);
    @(negedge clk);
    imem_ack = 1'b0;
    check("rw_late_inst", inst, 32'h0);
    check("rw_late_valid2", {31'b0, inst_valid}, 32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1111_1111;
    @(negedge clk);
    imem_ack = 1'b0;
    check("rw_refetch_inst", inst, 32'h1111_1111);
    check("rw_refetch_pc", pc, 32'h0);
`ifdef IFU_PERF_CNT_EN
    check("rw_perf_fetch", perf_fetch_cnt, 32'h0);
    check("rw_perf_redir", perf_redirect_cnt, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
